// File: rtl/eth_pkg.sv
// Shared Ethernet port datapath definitions: queue word layout and framer state encoding.
// Used by both the transmit and receive framers.
package eth_pkg;

  localparam int ETH_WORD_W     = 32;
  localparam int ETH_QW_SOP_BIT = 32;
  localparam int ETH_QW_EOP_BIT = 33;

  typedef struct packed {
    logic                  eop;
    logic                  sop;
    logic [ETH_WORD_W-1:0] data;
  } eth_qword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    GAP  = 2'd2
  } eth_xmit_state_t;

endpackage

// File: rtl/eth_xmit_ipg_cnt.sv
// Loadable down-counter for the inter-packet gap; o_done flags the decrement that reaches zero.
module eth_xmit_ipg_cnt #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // A stray decrement at zero also reports done so the owner can never get stuck.
  assign o_done = i_dec && (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/eth_xmit_fsm.sv
// Transmit framer: pops {eop,sop,payload} queue words, drives the framed port link and
// enforces the inter-packet gap. Define ETH_XMIT_STATS_EN to add packet/word/drop counters.
module eth_xmit_fsm
  import eth_pkg::*;
#(
  parameter int IPG_CYCLES = 2,
  parameter int WORD_W     = 32
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              inEmpty,
  output logic              inRdEn,
  input  logic [WORD_W+1:0] inData,
  output logic              outValid,
  output logic [WORD_W-1:0] outData,
  output logic              outSop,
  output logic              outEop,
  output logic              errFraming,
`ifdef ETH_XMIT_STATS_EN
  output logic              errUnderrun,
  output logic [15:0]       pktCnt,
  output logic [31:0]       wordCnt,
  output logic [15:0]       dropCnt
`else
  output logic              errUnderrun
`endif
);

  localparam int QW_W    = WORD_W + 2;
  localparam int EOP_BIT = WORD_W + 1;
  localparam int SOP_BIT = WORD_W;

  // The read latency after an EOP already yields one idle link cycle, so GAP only
  // covers the remaining IPG_CYCLES-1 cycles and is skipped below two.
  localparam bit EOP_STALL = (IPG_CYCLES != 0);
  localparam bit USE_GAP   = (IPG_CYCLES >= 2);
  localparam int CNT_W     = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(USE_GAP ? IPG_CYCLES - 1 : 0);

  eth_xmit_state_t r_state, w_state_next;

  logic            r_rd_pend;
  logic            r_hold_full, w_hold_full_next;
  logic [QW_W-1:0] r_hold, w_hold_next;
  logic            r_stall, w_stall_next;

  logic            w_cur_vld;
  logic [QW_W-1:0] w_cur;
  logic            w_eop_block;

  logic            w_ipg_load, w_ipg_dec, w_ipg_done;
  logic            w_emit, w_framing_next, w_underrun_next;

  logic              r_out_valid, r_out_sop, r_out_eop;
  logic [WORD_W-1:0] r_out_data;
  logic              r_err_framing, r_err_underrun;

  // A parked word always takes precedence over the FIFO return path.
  assign w_cur_vld   = r_hold_full | r_rd_pend;
  assign w_cur       = r_hold_full ? r_hold : inData;
  assign w_eop_block = EOP_STALL && w_cur_vld && w_cur[EOP_BIT];

  assign inRdEn = resetN && !inEmpty && (r_state != GAP) && !r_hold_full && !w_eop_block;

  eth_xmit_ipg_cnt #(
    .CNT_W (CNT_W)
  ) u_ipg_cnt (
    .clk        (clk),
    .resetN     (resetN),
    .i_load     (w_ipg_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_ipg_dec),
    .o_done     (w_ipg_done)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    w_stall_next     = r_stall;
    w_ipg_load       = 1'b0;
    w_ipg_dec        = 1'b0;
    w_emit           = 1'b0;
    w_framing_next   = 1'b0;
    w_underrun_next  = 1'b0;
    case (r_state)
      GAP: begin
        w_ipg_dec = 1'b1;
        if (r_rd_pend && !r_hold_full) begin
          w_hold_next      = inData;
          w_hold_full_next = 1'b1;
        end
        if (w_ipg_done) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        // Consuming the parked word; a word still returning takes its place.
        if (r_hold_full) begin
          w_hold_next      = inData;
          w_hold_full_next = r_rd_pend;
        end
        if (w_cur_vld) begin
          w_stall_next = 1'b0;
          if ((r_state == IDLE) && !w_cur[SOP_BIT]) begin
            w_framing_next = 1'b1;
          end else begin
            w_emit         = 1'b1;
            w_framing_next = (r_state == XMIT) && w_cur[SOP_BIT];
            if (!w_cur[EOP_BIT]) begin
              w_state_next = XMIT;
            end else if (USE_GAP) begin
              w_state_next = GAP;
              w_ipg_load   = 1'b1;
            end else begin
              w_state_next = IDLE;
            end
          end
        end else if (r_state == XMIT) begin
          w_stall_next    = 1'b1;
          w_underrun_next = !r_stall;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_rd_pend      <= 1'b0;
      r_hold_full    <= 1'b0;
      r_hold         <= '0;
      r_stall        <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_sop      <= 1'b0;
      r_out_eop      <= 1'b0;
      r_err_framing  <= 1'b0;
      r_err_underrun <= 1'b0;
    end else begin
      r_rd_pend      <= inRdEn;
      r_hold_full    <= w_hold_full_next;
      r_hold         <= w_hold_next;
      r_stall        <= w_stall_next;
      r_out_valid    <= w_emit;
      r_err_framing  <= w_framing_next;
      r_err_underrun <= w_underrun_next;
      if (w_emit) begin
        r_out_data <= w_cur[WORD_W-1:0];
        r_out_sop  <= w_cur[SOP_BIT];
        r_out_eop  <= w_cur[EOP_BIT];
      end
    end
  end

  assign outValid    = r_out_valid;
  assign outData     = r_out_data;
  assign outSop      = r_out_sop;
  assign outEop      = r_out_eop;
  assign errFraming  = r_err_framing;
  assign errUnderrun = r_err_underrun;

`ifdef ETH_XMIT_STATS_EN
  logic [15:0] r_pkt_cnt, r_drop_cnt;
  logic [31:0] r_word_cnt;
  logic        w_drop;

  assign w_drop = (r_state == IDLE) && w_cur_vld && !w_cur[SOP_BIT];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_pkt_cnt  <= '0;
      r_word_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_emit) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
      if (w_emit && w_cur[EOP_BIT]) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign pktCnt  = r_pkt_cnt;
  assign wordCnt = r_word_cnt;
  assign dropCnt = r_drop_cnt;
`endif

endmodule
